// File: rtl/bop_pkg.sv
// Shared types and constants for the BOP crash controller.
package bop_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CLEAR    = 3'd2,
    WAIT_LOW = 3'd3,
    HALTED   = 3'd4
  } bop_state_e;

  // One logged crash: offending PC and effective address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
  } bop_log_entry_t;

  // Default exception cause for a buffer-overflow/illegal-load crash.
  localparam logic [31:0] BOP_EXC_CAUSE = 32'h0000_0018;

endpackage : bop_pkg

// File: rtl/bop_log_fifo.sv
// Small synchronous FIFO of crash log entries with a sticky overflow flag.
module bop_log_fifo
  import bop_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  bop_log_entry_t i_data,
  input  logic           i_pop,
  output bop_log_entry_t o_data,
  output logic           o_empty,
  output logic           o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic           r_ovf;
  bop_log_entry_t r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Flags, and the accepted push/pop for this cycle.
  always_comb begin
    w_empty   = (r_wptr == r_rptr);
    w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  // Pointers and the sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_push && w_full && !i_pop) r_ovf <= 1'b1;
    end
  end

  // Entry storage; needs no reset because the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // Head entry and status outputs.
  always_comb begin
    o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    o_empty = w_empty;
    o_ovf   = r_ovf;
  end

endmodule : bop_log_fifo

// File: rtl/bop_crash_ctrl.sv
// Turns the detector's level crash flag into one handshaked exception request,
// clears the detector's range buffer afterwards, and logs offending PC/address pairs.
module bop_crash_ctrl
  import bop_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 4,
  parameter bit          STICKY    = 1'b0,
  parameter logic [31:0] EXC_CAUSE = BOP_EXC_CAUSE,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_crash_i,
  input  logic             crash_i,
  input  logic [31:0]      crash_pc_i,
  input  logic [31:0]      crash_addr_i,
  output logic             exc_req_o,
  output logic [31:0]      exc_cause_o,
  output logic [31:0]      exc_tval_o,
  input  logic             exc_ack_i,
  output logic             rst_buf_o,
  output logic             halt_o,
  input  logic             log_rd_i,
  output logic             log_valid_o,
  output logic [31:0]      log_pc_o,
  output logic [31:0]      log_addr_o,
  output logic             log_ovf_o,
  output logic [CNT_W-1:0] crash_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bop_state_e       r_state;
  bop_state_e       w_next;
  logic             r_crash_q;
  logic             r_halt_seen;
  logic [31:0]      r_tval;
  logic [CNT_W-1:0] r_crash_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_event;
  logic             w_accept;
  logic             w_drop;
  bop_log_entry_t   w_push_data;
  bop_log_entry_t   w_head;
  logic             w_log_empty;
  logic             w_log_ovf;

  // Rising-edge detect on the crash level, gated by the protection enable.
  always_comb begin
    w_event     = crash_i && !r_crash_q && en_crash_i;
    w_accept    = w_event && (r_state == IDLE);
    w_drop      = w_event && (r_state != IDLE);
    w_push_data = '{pc: crash_pc_i, addr: crash_addr_i};
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_accept)  w_next = REQ;
      REQ:      if (exc_ack_i) w_next = STICKY ? HALTED : CLEAR;
      CLEAR:    w_next = WAIT_LOW;
      WAIT_LOW: if (!crash_i)  w_next = IDLE;
      HALTED:   w_next = HALTED;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; the halt-entry pulse uses a one-cycle history bit.
  always_comb begin
    exc_req_o   = (r_state == REQ);
    exc_cause_o = EXC_CAUSE;
    exc_tval_o  = r_tval;
    rst_buf_o   = (r_state == CLEAR) || ((r_state == HALTED) && !r_halt_seen);
    halt_o      = (r_state == HALTED);
  end

  // Edge-detect history, halt-entry history and captured address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crash_q   <= 1'b0;
      r_halt_seen <= 1'b0;
      r_tval      <= '0;
    end else begin
      r_crash_q   <= crash_i;
      r_halt_seen <= (r_state == HALTED);
      if (w_accept) r_tval <= crash_addr_i;
    end
  end

  // Saturating accepted/dropped crash counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crash_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_accept && (r_crash_cnt != '1)) r_crash_cnt <= r_crash_cnt + CNT_ONE;
      if (w_drop   && (r_drop_cnt  != '1)) r_drop_cnt  <= r_drop_cnt  + CNT_ONE;
    end
  end

  bop_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_accept),
    .i_data  (w_push_data),
    .i_pop   (log_rd_i),
    .o_data  (w_head),
    .o_empty (w_log_empty),
    .o_ovf   (w_log_ovf)
  );

  // Log and counter outputs.
  always_comb begin
    log_valid_o = !w_log_empty;
    log_pc_o    = w_head.pc;
    log_addr_o  = w_head.addr;
    log_ovf_o   = w_log_ovf;
    crash_cnt_o = r_crash_cnt;
    drop_cnt_o  = r_drop_cnt;
  end

endmodule : bop_crash_ctrl

// File: tb/tb_bop_crash_ctrl.sv
// Bench for bop_crash_ctrl: a non-sticky instance and a sticky, shallow-log,
// narrow-counter instance share stimulus and are checked against a behavioural model.
module tb_bop_crash_ctrl;

  logic        clk, rst_i, en_crash_i, crash_i, exc_ack_i, log_rd_i;
  logic [31:0] crash_pc_i, crash_addr_i;

  logic        req0, rb0, halt0, lv0, lovf0;
  logic [31:0] cause0, tval0, lpc0, laddr0;
  logic [15:0] cc0, dc0;
  logic        req1, rb1, halt1, lv1, lovf1;
  logic [31:0] cause1, tval1, lpc1, laddr1;
  logic [1:0]  cc1, dc1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          run_cmp = 0;

  bop_crash_ctrl #(.LOG_DEPTH(4), .STICKY(1'b0), .EXC_CAUSE(32'h18), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_crash_i(en_crash_i), .crash_i(crash_i),
    .crash_pc_i(crash_pc_i), .crash_addr_i(crash_addr_i),
    .exc_req_o(req0), .exc_cause_o(cause0), .exc_tval_o(tval0), .exc_ack_i(exc_ack_i),
    .rst_buf_o(rb0), .halt_o(halt0), .log_rd_i(log_rd_i), .log_valid_o(lv0),
    .log_pc_o(lpc0), .log_addr_o(laddr0), .log_ovf_o(lovf0),
    .crash_cnt_o(cc0), .drop_cnt_o(dc0));

  bop_crash_ctrl #(.LOG_DEPTH(2), .STICKY(1'b1), .EXC_CAUSE(32'h18), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .en_crash_i(en_crash_i), .crash_i(crash_i),
    .crash_pc_i(crash_pc_i), .crash_addr_i(crash_addr_i),
    .exc_req_o(req1), .exc_cause_o(cause1), .exc_tval_o(tval1), .exc_ack_i(exc_ack_i),
    .rst_buf_o(rb1), .halt_o(halt1), .log_rd_i(log_rd_i), .log_valid_o(lv1),
    .log_pc_o(lpc1), .log_addr_o(laddr1), .log_ovf_o(lovf1),
    .crash_cnt_o(cc1), .drop_cnt_o(dc1));

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned M_DEPTH [2] = '{4, 2};
  int unsigned M_CMAX  [2] = '{65535, 3};
  bit          M_STICKY[2] = '{1'b0, 1'b1};

  bit          m_req [2];   // request outstanding
  bit          m_clr [2];   // buffer-clear pulse this cycle
  bit          m_wait[2];   // waiting for crash level to fall
  bit          m_halt[2];   // halted until reset
  bit          m_hp  [2];   // halt-entry clear pulse this cycle
  bit          m_ovf [2];
  logic [31:0] m_tval[2];
  int unsigned m_cc  [2];
  int unsigned m_dc  [2];
  logic [63:0] m_log [2][$];
  bit          m_cq;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_req[k] = 0; m_clr[k] = 0; m_wait[k] = 0; m_halt[k] = 0; m_hp[k] = 0;
      m_ovf[k] = 0; m_tval[k] = '0; m_cc[k] = 0; m_dc[k] = 0;
      m_log[k].delete();
    end
    m_cq = 0;
  endtask

  task automatic model_step();
    bit ev;
    ev = crash_i && !m_cq && en_crash_i;
    for (int k = 0; k < 2; k++) begin
      bit busy, was_req, was_clr, was_wait, push;
      busy     = m_req[k] || m_clr[k] || m_wait[k] || m_halt[k];
      was_req  = m_req[k];
      was_clr  = m_clr[k];
      was_wait = m_wait[k];
      push     = 0;
      m_clr[k] = 0;
      m_hp[k]  = 0;
      if (ev && !busy) begin
        m_tval[k] = crash_addr_i;
        m_req[k]  = 1;
        push      = 1;
        if (m_cc[k] < M_CMAX[k]) m_cc[k]++;
      end else if (ev) begin
        if (m_dc[k] < M_CMAX[k]) m_dc[k]++;
      end
      if (was_req && exc_ack_i) begin
        m_req[k] = 0;
        if (M_STICKY[k]) begin m_halt[k] = 1; m_hp[k] = 1; end
        else m_clr[k] = 1;
      end
      if (was_clr) m_wait[k] = 1;
      else if (was_wait && !crash_i) m_wait[k] = 0;
      if (log_rd_i && m_log[k].size() > 0) void'(m_log[k].pop_front());
      if (push) begin
        if (m_log[k].size() < M_DEPTH[k]) m_log[k].push_back({crash_pc_i, crash_addr_i});
        else m_ovf[k] = 1;
      end
    end
    m_cq = crash_i;
  endtask

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) model_reset();
    else       model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic req, input logic [31:0] cause,
                          input logic [31:0] tval, input logic rb, input logic halt,
                          input logic lv, input logic [31:0] lpc, input logic [31:0] laddr,
                          input logic lovf, input logic [63:0] cc, input logic [63:0] dc);
    logic [63:0] head;
    chk($sformatf("req%0d", k), 64'(req), 64'(m_req[k]));
    chk($sformatf("cause%0d", k), 64'(cause), 64'h18);
    if (m_req[k]) chk($sformatf("tval%0d", k), 64'(tval), 64'(m_tval[k]));
    chk($sformatf("rstbuf%0d", k), 64'(rb), 64'(m_clr[k] | m_hp[k]));
    chk($sformatf("halt%0d", k), 64'(halt), 64'(m_halt[k]));
    chk($sformatf("lvalid%0d", k), 64'(lv), 64'(m_log[k].size() > 0));
    if (m_log[k].size() > 0) begin
      head = m_log[k][0];
      chk($sformatf("lhead%0d", k), {lpc, laddr}, head);
    end
    chk($sformatf("lovf%0d", k), 64'(lovf), 64'(m_ovf[k]));
    chk($sformatf("ccnt%0d", k), cc, 64'(m_cc[k]));
    chk($sformatf("dcnt%0d", k), dc, 64'(m_dc[k]));
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp_inst(0, req0, cause0, tval0, rb0, halt0, lv0, lpc0, laddr0, lovf0, 64'(cc0), 64'(dc0));
      cmp_inst(1, req1, cause1, tval1, rb1, halt1, lv1, lpc1, laddr1, lovf1, 64'(cc1), 64'(dc1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_i = 1;
    crash_i = 0; exc_ack_i = 0; log_rd_i = 0;
    @(negedge clk);
    #2 rst_i = 0;
    @(negedge clk);
  endtask

  task automatic do_crash(input logic [31:0] pc, input logic [31:0] addr);
    crash_pc_i = pc; crash_addr_i = addr; crash_i = 1;
    cyc();
    exc_ack_i = 1;
    cyc();
    exc_ack_i = 0; crash_i = 0;
    cyc(2);
  endtask

  initial begin
    rst_i = 1; en_crash_i = 1; crash_i = 0; exc_ack_i = 0; log_rd_i = 0;
    crash_pc_i = '0; crash_addr_i = '0;
    cyc(2);
    #2 rst_i = 0;
    run_cmp = 1;
    cyc();

    // Reset state
    chk("rst_cause", 64'(cause0), 64'h18);
    chk("rst_req", 64'(req0), 64'h0);
    chk("rst_lpc", 64'(lpc0), 64'h0);
    chk("rst_ccnt", 64'(cc0), 64'h0);

    // First crash, ack three cycles later
    crash_pc_i = 32'h8000_0104; crash_addr_i = 32'h8000_2040; crash_i = 1;
    cyc();
    chk("t1_req", 64'(req0), 64'h1);
    chk("t1_tval", 64'(tval0), 64'h8000_2040);
    cyc(3);
    chk("t1_req_held", 64'(req0), 64'h1);
    exc_ack_i = 1;
    cyc();
    exc_ack_i = 0;
    chk("t1_rstbuf", 64'(rb0), 64'h1);
    chk("t1_req_drop", 64'(req0), 64'h0);
    chk("s_halt", 64'(halt1), 64'h1);
    chk("s_rstbuf", 64'(rb1), 64'h1);
    cyc();
    chk("t1_rstbuf_off", 64'(rb0), 64'h0);
    chk("s_rstbuf_off", 64'(rb1), 64'h0);
    chk("t1_log", {lpc0, laddr0}, 64'h8000_0104_8000_2040);
    chk("t1_ccnt", 64'(cc0), 64'h1);

    // Level held high: no re-trigger
    cyc(10);
    chk("t2_no_req", 64'(req0), 64'h0);
    chk("t2_dcnt", 64'(dc0), 64'h0);
    crash_i = 0;
    cyc(2);
    crash_pc_i = 32'h8000_0200; crash_addr_i = 32'h8000_3000; crash_i = 1;
    cyc();
    chk("t2_req", 64'(req0), 64'h1);
    chk("t2_ccnt", 64'(cc0), 64'h2);

    // Rise while requesting is dropped
    crash_i = 0;
    cyc();
    crash_i = 1;
    cyc();
    chk("t3_dcnt", 64'(dc0), 64'h1);
    chk("t3_req", 64'(req0), 64'h1);
    chk("t3_ccnt", 64'(cc0), 64'h2);
    exc_ack_i = 1;
    cyc();
    exc_ack_i = 0; crash_i = 0;
    cyc(3);

    // Drain log (two entries, extra pops ignored)
    log_rd_i = 1;
    cyc(4);
    log_rd_i = 0;
    chk("drain_valid", 64'(lv0), 64'h0);

    // Six crashes into a 4-deep log
    for (int i = 0; i < 6; i++) do_crash(32'h9000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    chk("ovf", 64'(lovf0), 64'h1);
    chk("ovf_ccnt", 64'(cc0), 64'h8);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_pc", 64'(lpc0), 64'(32'h9000_0000 + 32'(i * 4)));
      log_rd_i = 1;
      cyc();
    end
    log_rd_i = 0;
    chk("ovf_empty", 64'(lv0), 64'h0);
    chk("s_dcnt_sat", 64'(dc1), 64'h3);
    chk("s_ccnt", 64'(cc1), 64'h1);
    chk("s_halt_kept", 64'(halt1), 64'h1);

    // Reset clears sticky halt; then disabled protection
    do_reset();
    chk("s_halt_rst", 64'(halt1), 64'h0);
    en_crash_i = 0;
    for (int i = 0; i < 8; i++) begin
      crash_i = ~crash_i;
      cyc();
    end
    chk("en0_req", 64'(req0), 64'h0);
    chk("en0_ccnt", 64'(cc0), 64'h0);
    chk("en0_dcnt", 64'(dc0), 64'h0);
    en_crash_i = 1; crash_i = 0;
    cyc();

    // Reset mid-request
    crash_pc_i = 32'h1234_5678; crash_addr_i = 32'h0bad_0bad; crash_i = 1;
    cyc();
    chk("mid_req", 64'(req0), 64'h1);
    #2 rst_i = 1;
    #1;
    chk("mid_rst_req", 64'(req0), 64'h0);
    chk("mid_rst_rb", 64'(rb0), 64'h0);
    crash_i = 0;
    cyc();
    chk("mid_rst_rb2", 64'(rb0), 64'h0);
    #2 rst_i = 0;
    cyc();

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #2;
      if (rst_i) rst_i = 0;
      else if ($urandom_range(0, 399) == 0) rst_i = 1;
      if ($urandom_range(0, 3) == 0) crash_i = ~crash_i;
      en_crash_i   = ($urandom_range(0, 7) != 0);
      crash_pc_i   = $urandom;
      crash_addr_i = $urandom;
      exc_ack_i    = ($urandom_range(0, 2) == 0);
      log_rd_i     = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    #1;
    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bop_crash_ctrl

// File: doc/bop_crash_ctrl.md
Name: bop_crash_ctrl

Overview:
Downstream consumer of the buffer-overflow/illegal-load detector's crash indication. It converts the level-type crash flag into a single handshaked exception request toward the commit/exception logic. After the request is acknowledged it pulses a clear to the detector's range buffer and logs offending PC/address pairs in a small readable FIFO. An optional sticky mode halts the core until reset.

Parameters:
LOG_DEPTH, 4, log FIFO entries; power of two, at least 2.
STICKY, 0, 1 = enter HALTED after the first acknowledged crash.
EXC_CAUSE, 32'h18, value driven on exc_cause_o.
CNT_W, 16, width of the saturating crash and drop counters.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
en_crash_i  in  1  protection enable; also gates detection
crash_i  in  1  level crash flag from the detector
crash_pc_i  in  32  PC of the instruction in the detector this cycle
crash_addr_i  in  32  effective address of that instruction
exc_req_o  out  1  exception request, held until acknowledged
exc_cause_o  out  32  cause code, constant EXC_CAUSE
exc_tval_o  out  32  captured crash address
exc_ack_i  in  1  commit logic accepts the exception
rst_buf_o  out  1  one-cycle clear to the detector's range buffer
halt_o  out  1  core halt (STICKY only)
log_rd_i  in  1  pop one log entry
log_valid_o  out  1  log not empty
log_pc_o  out  32  head entry PC
log_addr_o  out  32  head entry address
log_ovf_o  out  1  sticky: an entry was discarded because the log was full
crash_cnt_o  out  CNT_W  accepted crashes, saturating
drop_cnt_o  out  CNT_W  crashes seen while busy, saturating

Behaviour:
- Reset, async on rst_i high:
  - state = IDLE.
  - All outputs 0 except exc_cause_o = EXC_CAUSE.
  - Log empty, counters 0, crash_q = 0.
- Edge detect:
  - crash_q registers crash_i every cycle.
  - event = crash_i & ~crash_q & en_crash_i.
- IDLE:
  - On event: capture crash_pc_i/crash_addr_i into pc_r/tval_r.
  - Push the pair to the log.
  - crash_cnt +1, saturating.
  - Next state REQ, so exc_req_o rises 1 cycle after the crash_i rise.
- REQ:
  - exc_req_o = 1 and exc_tval_o = tval_r, both stable until ack.
  - On exc_ack_i: go to CLEAR, or to HALTED if STICKY = 1.
  - An ack arriving in any other state is ignored.
- CLEAR:
  - rst_buf_o = 1 for exactly this one cycle, then go to WAIT_LOW.
- WAIT_LOW:
  - Stay while crash_i = 1; return to IDLE when crash_i = 0.
  - This prevents a stale level from re-triggering.
- HALTED:
  - halt_o = 1 and rst_buf_o is pulsed on entry (1 cycle).
  - Only reset leaves this state.
- Event seen in REQ, CLEAR, WAIT_LOW or HALTED: not logged, no request; drop_cnt +1, saturating.
- en_crash_i falling while in REQ: the request is still held until ack. No withdrawal of a valid-asserted request.
- Log FIFO:
  - Read and write pointers of log2(LOG_DEPTH)+1 bits; wrap at LOG_DEPTH.
  - Head outputs are combinational from storage and valid when log_valid_o = 1.
  - Pop when empty: ignored.
  - Push when full with no pop: entry discarded, log_ovf_o set until reset.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
- Counters saturate at all-ones and never wrap.
- Reset mid-REQ: exc_req_o drops asynchronously and no rst_buf_o pulse is produced.

Decomposition:
- Shared package (bop_pkg), holding:
  - the state enum (IDLE, REQ, CLEAR, WAIT_LOW, HALTED);
  - the log entry struct {pc[31:0], addr[31:0]};
  - the default BOP exception cause constant.
- One sub-module: bop_log_fifo, a parameterised synchronous FIFO with async active-high reset, full/empty flags and overflow flag.
- The FSM and counters live in the top module.

Test Plan:
- Reset, then crash_i rises with pc 0x8000_0104 and addr 0x8000_2040, en_crash_i = 1:
  - exc_req_o = 1 the next cycle with tval 0x8000_2040.
  - Ack 3 cycles later: rst_buf_o pulses 1 cycle.
  - Log holds {0x8000_0104, 0x8000_2040}; crash_cnt_o = 1.
- crash_i held high for 10 cycles after ack:
  - Stays in WAIT_LOW, no second request; drop_cnt_o = 0.
  - crash_i low then high again: second request issued, crash_cnt_o = 2.
- Second crash_i rise while in REQ: drop_cnt_o = 1, log count unchanged, exc_req_o stays 1 until ack.
- Six accepted crashes with no log_rd_i and LOG_DEPTH = 4:
  - log_ovf_o = 1; four pops return the first four PCs in order; log_valid_o = 0 after them.
- STICKY = 1, crash then ack:
  - halt_o = 1 permanently and rst_buf_o pulses once.
  - A further crash increments drop_cnt_o only; rst_i clears all state.
- en_crash_i = 0 with crash_i toggling: no request, counters stay 0.
- rst_i asserted mid-REQ: exc_req_o = 0 immediately and no rst_buf_o pulse.
